gpu_mem_arbiter: RTL and testbench

- Downstream of the per-tile gpu_controller instances: merges their byte-wide m1 Avalon-MM masters onto one shared byte master toward SDRAM/on-chip memory.
- Round-robin arbitration, one outstanding read per tile, in-order read-response routing via an ID FIFO.
- Matches the controller's read handshake: the controller holds read high until it sees waitrequest low together with readdatavalid high.

---
 rtl/gpu_mem_arbiter_pkg.sv | 25 ++
 rtl/gpu_rr_arbiter.sv | 27 ++
 rtl/gpu_mem_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_gpu_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_mem_arbiter_pkg.sv
// Shared types and defaults for merging per-tile gpu_controller byte masters onto one memory port.
// Sizes here match the gpu_controller's m1 master so the bus command struct lines up on both sides.
package gpu_mem_arbiter_pkg;

  localparam int GPU_NUM_MASTERS = 4;
  localparam int GPU_ADDR_BITS   = 32;
  localparam int GPU_DATA_BITS   = 8;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [GPU_ADDR_BITS-1:0] address;
    logic [GPU_DATA_BITS-1:0] writedata;
    logic                     read;
    logic                     write;
  } gpu_bus_cmd_t;

  function automatic int gpu_id_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpu_rr_arbiter.sv
// Combinational round-robin pick: the search begins one past last_i and wraps, so the
// most recently served master becomes the lowest priority.
module gpu_rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] last_i,
  output logic [N-1:0]   gnt_o,
  output logic           vld_o
);

  always_comb begin
    logic [IDW-1:0] idx;
    gnt_o = '0;
    vld_o = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDW'((int'(last_i) + k) % N);
      if (!vld_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        vld_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpu_mem_arbiter.sv
// Round-robin merge of per-tile byte masters; command issues the cycle after the grant, writes
// complete on accept, reads stay stalled until their in-order response is routed back by an ID FIFO.
module gpu_mem_arbiter
  import gpu_mem_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = GPU_NUM_MASTERS,
  parameter int ADDR_BITS   = GPU_ADDR_BITS,
  parameter int DATA_BITS   = GPU_DATA_BITS,
  parameter int ID_BITS     = gpu_id_bits(NUM_MASTERS)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_MASTERS*ADDR_BITS-1:0] s_address,
  input  logic [NUM_MASTERS*DATA_BITS-1:0] s_writedata,
  input  logic [NUM_MASTERS-1:0]           s_write,
  input  logic [NUM_MASTERS-1:0]           s_read,
  output logic [NUM_MASTERS-1:0]           s_waitrequest,
  output logic [DATA_BITS-1:0]             s_readdata,
  output logic [NUM_MASTERS-1:0]           s_readdatavalid,
  output logic [ADDR_BITS-1:0]             m_address,
  output logic [DATA_BITS-1:0]             m_writedata,
  output logic                             m_write,
  output logic                             m_read,
  input  logic                             m_waitrequest,
  input  logic [DATA_BITS-1:0]             m_readdata,
  input  logic                             m_readdatavalid
);

  localparam logic [ID_BITS-1:0] LAST_IDX  = ID_BITS'(NUM_MASTERS - 1);
  localparam logic [ID_BITS:0]   FIFO_FULL = (ID_BITS+1)'(NUM_MASTERS);

  arb_state_e                 state_q, state_d;
  logic [ID_BITS-1:0]         grant_q, grant_d;
  logic [ID_BITS-1:0]         rr_q, rr_d;
  logic [NUM_MASTERS-1:0]     pending_q, pending_d;
  logic [ID_BITS-1:0]         fifo_q [NUM_MASTERS];
  logic [ID_BITS-1:0]         wr_ptr_q, wr_ptr_d;
  logic [ID_BITS-1:0]         rd_ptr_q, rd_ptr_d;
  logic [ID_BITS:0]           count_q, count_d;

  logic [ADDR_BITS-1:0]       addr_a  [NUM_MASTERS];
  logic [DATA_BITS-1:0]       wdata_a [NUM_MASTERS];
  gpu_bus_cmd_t               cmd;
  logic                       busy_req;
  logic                       accept;
  logic                       acc_rd;
  logic                       acc_wr;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       pop;
  logic [ID_BITS-1:0]         head;
  logic [NUM_MASTERS-1:0]     eligible;
  logic [NUM_MASTERS-1:0]     arb_req;
  logic [NUM_MASTERS-1:0]     arb_gnt;
  logic                       arb_vld;
  logic [ID_BITS-1:0]         arb_idx;

  function automatic logic [NUM_MASTERS-1:0] to_onehot(input logic [ID_BITS-1:0] idx);
    logic [NUM_MASTERS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign addr_a[i]  = s_address[i*ADDR_BITS +: ADDR_BITS];
    assign wdata_a[i] = s_writedata[i*DATA_BITS +: DATA_BITS];
  end

  assign fifo_full  = (count_q == FIFO_FULL);
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_q[rd_ptr_q];
  // Stale responses (FIFO empty, e.g. issued before reset) are silently dropped.
  assign pop        = m_readdatavalid & ~fifo_empty;

  // Granted command; write wins when a port raises both strobes.
  always_comb begin
    cmd      = '0;
    busy_req = (state_q == ARB_BUSY) && (s_read[grant_q] || s_write[grant_q]);
    if (busy_req) begin
      cmd.address   = addr_a[grant_q];
      cmd.writedata = wdata_a[grant_q];
      cmd.write     = s_write[grant_q];
      cmd.read      = s_read[grant_q] & ~s_write[grant_q];
    end
  end

  assign accept = busy_req & ~m_waitrequest;
  assign acc_rd = accept & cmd.read;
  assign acc_wr = accept & cmd.write;

  assign eligible = (s_read | s_write) & ~pending_q & ~(s_read & {NUM_MASTERS{fifo_full}});
  assign arb_req  = eligible & ((state_q == ARB_BUSY) ? ~to_onehot(grant_q) : '1);

  gpu_rr_arbiter #(
    .N   (NUM_MASTERS),
    .IDW (ID_BITS)
  ) u_rr (
    .req_i  (arb_req),
    .last_i (rr_q),
    .gnt_o  (arb_gnt),
    .vld_o  (arb_vld)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (arb_gnt[i]) arb_idx = ID_BITS'(i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    case (state_q)
      ARB_IDLE: begin
        if (arb_vld) begin
          state_d = ARB_BUSY;
          grant_d = arb_idx;
          rr_d    = arb_idx;
        end
      end
      ARB_BUSY: begin
        if (!busy_req) begin
          state_d = ARB_IDLE;
        end else if (accept) begin
          if (arb_vld) begin
            grant_d = arb_idx;
            rr_d    = arb_idx;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    m_address       = cmd.address;
    m_writedata     = cmd.writedata;
    m_read          = cmd.read;
    m_write         = cmd.write;
    s_readdata      = m_readdata;
    s_readdatavalid = pop ? to_onehot(head) : '0;
    s_waitrequest   = '1;
    if (acc_wr) s_waitrequest[grant_q] = 1'b0;
    if (pop)    s_waitrequest[head]    = 1'b0;
  end

  // Read-ID FIFO and per-port outstanding flags. A port can hold at most one read, so
  // NUM_MASTERS entries never overflow; head and grant are distinct ports when both fire.
  always_comb begin
    pending_d = pending_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (pop) begin
      pending_d[head] = 1'b0;
      rd_ptr_d        = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
    end
    if (acc_rd) begin
      pending_d[grant_q] = 1'b1;
      wr_ptr_d           = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
    end
    case ({acc_rd, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (acc_rd) fifo_q[wr_ptr_q] <= grant_q;
  end

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Scoreboard bench for gpu_mem_arbiter: directed requests push expected commands/responses,
// a negedge monitor pops and compares whenever the DUT issues or returns something.
module tb_gpu_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 8;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N*AW-1:0] s_address = '0;
  logic [N*DW-1:0] s_writedata = '0;
  logic [N-1:0]    s_write = '0;
  logic [N-1:0]    s_read = '0;
  logic [N-1:0]    s_waitrequest;
  logic [DW-1:0]   s_readdata;
  logic [N-1:0]    s_readdatavalid;
  logic [AW-1:0]   m_address;
  logic [DW-1:0]   m_writedata;
  logic            m_write;
  logic            m_read;
  logic            m_waitrequest = 1'b0;
  logic [DW-1:0]   m_readdata = '0;
  logic            m_readdatavalid = 1'b0;

  gpu_mem_arbiter dut (
    .clock           (clock),
    .reset           (reset),
    .s_address       (s_address),
    .s_writedata     (s_writedata),
    .s_write         (s_write),
    .s_read          (s_read),
    .s_waitrequest   (s_waitrequest),
    .s_readdata      (s_readdata),
    .s_readdatavalid (s_readdatavalid),
    .m_address       (m_address),
    .m_writedata     (m_writedata),
    .m_write         (m_write),
    .m_read          (m_read),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          wr;
    int          port;
    logic [31:0] addr;
    logic [7:0]  dat;
  } cmd_t;

  typedef struct {
    logic [3:0] oh;
    logic [7:0] dat;
  } rsp_t;

  cmd_t       exp_cmd[$];
  rsp_t       exp_rsp[$];
  logic [7:0] rd_plan[$];
  int         mem_due[$];
  logic [7:0] mem_dat[$];

  int         cyc = 0;
  int         lat = 2;
  int         tests = 0;
  int         fails = 0;
  bit         stale = 1'b0;
  logic [3:0] done_q = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Memory model: each accepted read answers lat cycles later with the next planned byte.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (mem_due.size() > 0 && mem_due[0] == cyc) begin
        m_readdatavalid = 1'b1;
        m_readdata      = mem_dat.pop_front();
        void'(mem_due.pop_front());
      end else begin
        m_readdatavalid = 1'b0;
        m_readdata      = '0;
      end
    end
  end

  cmd_t       mon_c;
  rsp_t       mon_r;
  logic [3:0] expw;

  always @(negedge clock) begin
    if (reset) begin
      done_q = '0;
    end else begin
      done_q = (s_write & ~s_waitrequest) | (s_read & ~s_waitrequest & s_readdatavalid);
      expw   = '1;
      if ((m_read || m_write) && !m_waitrequest) begin
        if (m_read) begin
          mem_due.push_back(cyc + lat);
          mem_dat.push_back(rd_plan.size() > 0 ? rd_plan.pop_front() : 8'hEE);
        end
        if (exp_cmd.size() == 0) begin
          chk("cmd_unexpected", m_address, 32'hFFFF_FFFF);
        end else begin
          mon_c = exp_cmd.pop_front();
          chk("cmd_write", 32'(m_write), 32'(mon_c.wr));
          chk("cmd_read", 32'(m_read), 32'(!mon_c.wr));
          chk("cmd_addr", m_address, mon_c.addr);
          if (mon_c.wr) begin
            chk("cmd_wdata", 32'(m_writedata), 32'(mon_c.dat));
            expw[mon_c.port] = 1'b0;
          end
        end
      end
      if (m_readdatavalid) begin
        if (stale) begin
          chk("stale_rdv", 32'(s_readdatavalid), 32'h0);
        end else if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", 32'(s_readdatavalid), 32'h0);
        end else begin
          mon_r = exp_rsp.pop_front();
          chk("rsp_route", 32'(s_readdatavalid), 32'(mon_r.oh));
          chk("rsp_data", 32'(s_readdata), 32'(mon_r.dat));
          expw = expw & ~mon_r.oh;
        end
      end else begin
        chk("rdv_quiet", 32'(s_readdatavalid), 32'h0);
      end
      chk("waitreq", 32'(s_waitrequest), 32'(expw));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    s_read  = s_read & ~done_q;
    s_write = s_write & ~done_q;
  endtask

  task automatic issue_rd(input int p, input logic [31:0] a, input logic [7:0] d, input bit rsp);
    s_address[p*AW +: AW] = a;
    s_read[p]             = 1'b1;
    exp_cmd.push_back('{1'b0, p, a, 8'h00});
    rd_plan.push_back(d);
    if (rsp) exp_rsp.push_back('{4'b0001 << p, d});
  endtask

  task automatic issue_wr(input int p, input logic [31:0] a, input logic [7:0] d);
    s_address[p*AW +: AW]   = a;
    s_writedata[p*DW +: DW] = d;
    s_write[p]              = 1'b1;
    exp_cmd.push_back('{1'b1, p, a, d});
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_cmd.size() + exp_rsp.size() + mem_due.size() > 0 || s_read != 0 || s_write != 0)
           && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(exp_cmd.size() + exp_rsp.size() + mem_due.size()), 32'h0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_m_read"}, 32'(m_read), 32'h0);
    chk({tag, "_m_write"}, 32'(m_write), 32'h0);
    chk({tag, "_m_address"}, m_address, 32'h0);
    chk({tag, "_m_writedata"}, 32'(m_writedata), 32'h0);
    chk({tag, "_s_waitreq"}, 32'(s_waitrequest), 32'hF);
    chk({tag, "_s_rdv"}, 32'(s_readdatavalid), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clock);
    check_reset("por");
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();

    // Single read on port 1, memory answers two cycles after accept.
    lat = 2;
    issue_rd(1, 32'h0000_0100, 8'h5A, 1'b1);
    @(negedge clock);
    chk("single_decide_idle", 32'(m_read), 32'h0);
    tick();
    @(negedge clock);
    chk("single_m_read", 32'(m_read), 32'h1);
    chk("single_m_addr", m_address, 32'h0000_0100);
    wait_quiet("single_drain", 20);

    // Port 2 write stalled five cycles while port 3 also waits; rr last=1 so port 2 wins.
    m_waitrequest = 1'b1;
    issue_wr(2, 32'h0000_2000, 8'h33);
    issue_wr(3, 32'h0000_3000, 8'h77);
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("stall_m_write", 32'(m_write), 32'h1);
      chk("stall_m_addr", m_address, 32'h0000_2000);
      chk("stall_m_wdata", 32'(m_writedata), 32'h33);
      tick();
    end
    m_waitrequest = 1'b0;
    wait_quiet("stall_drain", 20);

    // Four-way read contention after last grant 3: grants 0,1,2,3 back to back.
    lat = 3;
    for (int p = 0; p < 4; p++) issue_rd(p, 32'h1000 + 32'(p) * 32'h10, 8'hA0 + 8'(p), 1'b1);
    tick();
    for (int p = 0; p < 4; p++) begin
      @(negedge clock);
      chk("contend_m_read", 32'(m_read), 32'h1);
      chk("contend_order", m_address, 32'h1000 + 32'(p) * 32'h10);
      tick();
    end
    wait_quiet("contend_drain", 40);

    // Fairness wrap: last grant 3, ports 0 and 3 write -> 0 then 3.
    issue_wr(0, 32'h0000_0010, 8'h11);
    issue_wr(3, 32'h0000_0030, 8'h33);
    tick();
    @(negedge clock);
    chk("wrap_first", m_address, 32'h0000_0010);
    tick();
    @(negedge clock);
    chk("wrap_second", m_address, 32'h0000_0030);
    wait_quiet("wrap_drain", 20);

    // Port 0 response lands in the same cycle port 1's read is accepted.
    lat = 1;
    issue_rd(0, 32'h0000_0500, 8'h55, 1'b1);
    issue_rd(1, 32'h0000_0510, 8'h66, 1'b1);
    tick();
    tick();
    @(negedge clock);
    chk("overlap_rdv", 32'(s_readdatavalid), 32'h1);
    chk("overlap_m_read", 32'(m_read), 32'h1);
    chk("overlap_m_addr", m_address, 32'h0000_0510);
    wait_quiet("overlap_drain", 20);

    // Reset with two reads outstanding; their late responses must be dropped.
    lat = 8;
    issue_rd(2, 32'h0000_4200, 8'hC1, 1'b0);
    issue_rd(3, 32'h0000_4300, 8'hC2, 1'b0);
    repeat (3) tick();
    reset   = 1'b1;
    stale   = 1'b1;
    s_read  = '0;
    s_write = '0;
    @(negedge clock);
    check_reset("midrst");
    tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      @(negedge clock);
      chk("stale_m_read", 32'(m_read), 32'h0);
      chk("stale_waitreq", 32'(s_waitrequest), 32'hF);
    end
    chk("stale_delivered", 32'(mem_due.size()), 32'h0);
    stale = 1'b0;

    // After reset the rr pointer is 0 and the FIFO empty: a fresh port 0 read routes cleanly.
    lat = 2;
    issue_rd(0, 32'h0000_0600, 8'h3C, 1'b1);
    wait_quiet("post_reset_drain", 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
